// File: rtl/histo_frame_ctrl.sv
// rtl/histo_frame_ctrl.sv - frame histogram controller: accumulate pixels, then drain every bin downstream
// Defining HISTO_FRAME_CTRL_SUMCHK_EN adds sum_err, a check that drained bin counts add up to the pixel count.
module histo_frame_ctrl #(
  parameter int NUM_BINS = 1024,
  parameter int RD_LAT   = 1,
  parameter int CNT_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic [9:0]       pix_in,
  input  logic             pix_valid_in,
  output logic             hist_rw,
  output logic [9:0]       hist_pixel,
  output logic             hist_pixel_valid,
  output logic [9:0]       hist_bin,
  input  logic [CNT_W-1:0] hist_data,
  output logic [9:0]       out_bin,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             frame_drop,
`ifdef HISTO_FRAME_CTRL_SUMCHK_EN
  output logic [CNT_W-1:0] pix_count,
  output logic             sum_err
`else
  output logic [CNT_W-1:0] pix_count
`endif
);

  localparam logic [9:0] LAST_BIN  = 10'(NUM_BINS - 1);
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_ADDR, S_WAIT, S_PRESENT, S_DONE
  } state_t;

  state_t           state_q;
  logic             end_seen_q;
  logic             hist_rw_q;
  logic [9:0]       hist_pixel_q;
  logic             hist_pixel_valid_q;
  logic [9:0]       bin_q;
  logic [9:0]       bin_d;
  logic [2:0]       wait_q;
  logic [9:0]       out_bin_q;
  logic [CNT_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             busy_q;
  logic             frame_drop_q;
  logic [CNT_W-1:0] pix_count_q;
  logic [CNT_W-1:0] pix_count_d;

  assign hist_rw          = hist_rw_q;
  assign hist_pixel       = hist_pixel_q;
  assign hist_pixel_valid = hist_pixel_valid_q;
  assign hist_bin         = bin_q;
  assign out_bin          = out_bin_q;
  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;
  assign busy             = busy_q;
  assign frame_drop       = frame_drop_q;
  assign pix_count        = pix_count_q;

  always_comb begin
    pix_count_d = (&pix_count_q) ? pix_count_q : pix_count_q + CNT_W'(1);
    bin_d       = bin_q + 10'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      end_seen_q         <= 1'b0;
      hist_rw_q          <= 1'b0;
      hist_pixel_q       <= '0;
      hist_pixel_valid_q <= 1'b0;
      bin_q              <= '0;
      wait_q             <= '0;
      out_bin_q          <= '0;
      out_data_q         <= '0;
      out_valid_q        <= 1'b0;
      out_last_q         <= 1'b0;
      busy_q             <= 1'b0;
      frame_drop_q       <= 1'b0;
      pix_count_q        <= '0;
    end else begin
      frame_drop_q <= frame_start && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q     <= S_ACCUM;
            busy_q      <= 1'b1;
            hist_rw_q   <= 1'b1;
            pix_count_q <= '0;
            end_seen_q  <= frame_end;
          end
        end
        S_ACCUM: begin
          // After frame_end, one more cycle lets the last registered pixel reach the histogram.
          if (end_seen_q) begin
            state_q            <= S_ADDR;
            end_seen_q         <= 1'b0;
            hist_rw_q          <= 1'b0;
            hist_pixel_valid_q <= 1'b0;
          end else begin
            hist_pixel_q       <= pix_in;
            hist_pixel_valid_q <= pix_valid_in;
            if (pix_valid_in) pix_count_q <= pix_count_d;
            if (frame_end) end_seen_q <= 1'b1;
          end
        end
        S_ADDR: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            out_data_q  <= hist_data;
            out_bin_q   <= bin_q;
            out_last_q  <= (bin_q == LAST_BIN);
            out_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (bin_q == LAST_BIN) begin
              state_q <= S_DONE;
            end else begin
              bin_q   <= bin_d;
              state_q <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          bin_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef HISTO_FRAME_CTRL_SUMCHK_EN
  // Compared against an unsaturated pixel count so large frames still check exactly.
  logic [CNT_W+9:0] sum_q;
  logic [CNT_W+9:0] raw_cnt_q;
  logic             sum_err_q;

  assign sum_err = sum_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      raw_cnt_q <= '0;
      sum_err_q <= 1'b0;
    end else if (state_q == S_IDLE && frame_start) begin
      sum_q     <= '0;
      raw_cnt_q <= '0;
      sum_err_q <= 1'b0;
    end else begin
      if (state_q == S_ACCUM && !end_seen_q && pix_valid_in) raw_cnt_q <= raw_cnt_q + 1'b1;
      if (state_q == S_PRESENT && out_ready) sum_q <= sum_q + {10'b0, out_data_q};
      if (state_q == S_DONE) sum_err_q <= (sum_q != raw_cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_histo_frame_ctrl.sv
// tb/tb_histo_frame_ctrl.sv - scoreboard bench for histo_frame_ctrl with a read-clears histogram model
module tb_histo_frame_ctrl;

  localparam int CNT_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             frame_start = 0, frame_end = 0, pix_valid_in = 0, out_ready = 1;
  logic [9:0]       pix_in = '0;
  logic             hist_rw, hist_pixel_valid, out_valid, out_last, busy, frame_drop;
  logic [9:0]       hist_pixel, hist_bin, out_bin;
  logic [CNT_W-1:0] hist_data, out_data, pix_count;
`ifdef HISTO_FRAME_CTRL_SUMCHK_EN
  logic             sum_err;
`endif

  histo_frame_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .pix_in(pix_in), .pix_valid_in(pix_valid_in), .hist_rw(hist_rw),
    .hist_pixel(hist_pixel), .hist_pixel_valid(hist_pixel_valid), .hist_bin(hist_bin),
    .hist_data(hist_data), .out_bin(out_bin), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_drop(frame_drop),
`ifdef HISTO_FRAME_CTRL_SUMCHK_EN
    .sum_err(sum_err),
`endif
    .pix_count(pix_count)
  );

  // Histogram memory: accumulate when hist_rw=1, otherwise read hist_bin (latency 1) and clear it.
  logic [CNT_W-1:0] mem [1024];
  logic [CNT_W-1:0] rd_q = '0;
  int fault_bin = -1;
  assign hist_data = rd_q;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (hist_rw) begin
      if (hist_pixel_valid) mem[hist_pixel] <= mem[hist_pixel] + 24'd1;
    end else begin
      rd_q <= mem[hist_bin] + ((int'(hist_bin) == fault_bin) ? 24'd1 : 24'd0);
      mem[hist_bin] <= '0;
    end
  end

  typedef struct packed {
    logic [9:0]       bin;
    logic [CNT_W-1:0] data;
    logic             last;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t exp_e;
  int    exp_cnt [1024];
  int    n_chk = 0, n_fail = 0;
  int    drop_cnt = 0, stall7_cnt = 0;
  logic  prev_stall = 0;
  logic [9:0]       prev_bin;
  logic [CNT_W-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {out_valid, out_bin, out_data}, {1'b1, prev_bin, prev_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {out_bin, out_data}, 64'hDEAD);
        end else begin
          exp_e = exp_q.pop_front();
          check("xfer", {out_bin, out_data, out_last}, exp_e);
        end
      end
      if (out_valid && !out_ready && out_bin == 10'd7) stall7_cnt++;
      if (frame_drop) drop_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_bin   = out_bin;
      prev_data  = out_data;
    end
  end

  task automatic clear_exp();
    for (int b = 0; b < 1024; b++) exp_cnt[b] = 0;
  endtask

  task automatic push_frame(input int nbins);
    for (int b = 0; b < nbins; b++)
      exp_q.push_back({10'(b), CNT_W'(exp_cnt[b]), b == 1023});
  endtask

  // Negative entries are idle cycles with valid low and a non-zero pixel value on the bus.
  task automatic send_frame(input int px[$]);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < px.size(); i++) begin
      pix_in       = (px[i] >= 0) ? 10'(px[i]) : 10'd5;
      pix_valid_in = (px[i] >= 0);
      frame_end    = (i == px.size() - 1);
      @(posedge clk); #1;
    end
    pix_valid_in = 1'b0;
    frame_end    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n < 20000, 1'b1);
  endtask

  task automatic wait_bin(input logic [9:0] b, input logic need_valid);
    int n = 0;
    while (!(hist_bin == b && out_valid == need_valid) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_bin_timeout", n < 20000, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int px[$];
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {hist_rw, out_valid, frame_drop, busy, hist_pixel_valid}, 5'b0);
    check("rst_pix_count", pix_count, 0);
    check("rst_out_data", {out_data, hist_bin}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    @(posedge clk); #1;
    check("frame_end_idle_busy", busy, 1'b0);

    // Frame 1: {3,3,7,(idle),1023,0}, then frame_start while in DONE must drop.
    clear_exp();
    exp_cnt[3] = 2; exp_cnt[7] = 1; exp_cnt[1023] = 1; exp_cnt[0] = 1;
    push_frame(1024);
    px = {3, 3, 7, -1, 1023, 0};
    send_frame(px);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && out_last) && n < 20000);
    check("f1_last_timeout", n < 20000, 1'b1);
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(posedge clk); #1;
    check("f1_busy_after_done_drop", busy, 1'b0);
    check("f1_drop_cnt", drop_cnt, 1);
    check("f1_pix_count", pix_count, 5);
    check("f1_queue_empty", exp_q.size(), 0);

    // Frame 2: stall at bin 7 for 20 cycles, frame_start during drain.
    clear_exp();
    exp_cnt[1] = 1; exp_cnt[2] = 2;
    push_frame(1024);
    px = {1, -1, 2, 2};
    send_frame(px);
    wait_bin(10'd7, 1'b0);
    out_ready = 1'b0;
    wait_bin(10'd7, 1'b1);
    repeat (20) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_bin(10'd100, 1'b0);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("f2_busy_during_drop", busy, 1'b1);
    wait_idle("f2_idle_timeout");
    check("f2_drop_cnt", drop_cnt, 2);
    check("f2_stall7_cnt", stall7_cnt, 20);
    check("f2_pix_count", pix_count, 3);
    check("f2_queue_empty", exp_q.size(), 0);

    // Frame 3: reset once bin 500 is addressed; only bins 0..499 transfer.
    clear_exp();
    exp_cnt[3] = 2; exp_cnt[7] = 1; exp_cnt[0] = 1;
    push_frame(500);
    px = {3, 3, 7, 1023, 0};
    send_frame(px);
    wait_bin(10'd500, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("f3_rst_outs", {out_valid, busy, hist_rw, frame_drop}, 4'b0);
    check("f3_rst_pix_count", pix_count, 0);
    check("f3_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 4: restarts at bin 0; bin 1023 still holds the count left by frame 3.
    clear_exp();
    exp_cnt[5] = 1; exp_cnt[1023] = 1;
    push_frame(1024);
    px = {5};
    send_frame(px);
    wait_idle("f4_idle_timeout");
    check("f4_pix_count", pix_count, 1);
    check("f4_queue_empty", exp_q.size(), 0);

    // Frame 5: frame_start and frame_end together -> empty frame.
    clear_exp();
    push_frame(1024);
    frame_start = 1'b1;
    frame_end   = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    wait_idle("f5_idle_timeout");
    check("f5_pix_count", pix_count, 0);
    check("f5_queue_empty", exp_q.size(), 0);

`ifdef HISTO_FRAME_CTRL_SUMCHK_EN
    clear_exp();
    exp_cnt[4] = 1; exp_cnt[9] = 1;
    push_frame(1024);
    fault_bin = 9;
    px = {4};
    send_frame(px);
    wait_idle("f6_idle_timeout");
    check("f6_sum_err", sum_err, 1'b1);
    fault_bin = -1;
    clear_exp();
    exp_cnt[4] = 1;
    push_frame(1024);
    send_frame(px);
    wait_idle("f7_idle_timeout");
    check("f7_sum_err", sum_err, 1'b0);
    check("f7_queue_empty", exp_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/histo_frame_ctrl.md
HISTO_FRAME_CTRL -- requirements
Module: histo_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_BINS, default 1024, number of histogram bins (power of two, 2..1024).
REQ-002 SHALL have parameter RD_LAT, default 1, clk cycles from hist_bin change to valid hist_data (1..4).
REQ-003 SHALL have parameter CNT_W, default 24, bin count width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse, first pixel of a frame follows.
REQ-007 SHALL have port frame_end  input  1  one-cycle pulse, last pixel of the frame has been presented.
REQ-008 SHALL have port pix_in  input  10  pixel value.
REQ-009 SHALL have port pix_valid_in  input  1  pix_in qualifier.
REQ-010 SHALL have port hist_rw  output  1  histogram mode, 1 = accumulate, 0 = read/clear.
REQ-011 SHALL have port hist_pixel  output  10  pixel forwarded to the histogram.
REQ-012 SHALL have port hist_pixel_valid  output  1  forwarded pixel qualifier.
REQ-013 SHALL have port hist_bin  output  10  bin address for read-out.
REQ-014 SHALL have port hist_data  input  CNT_W  bin count from the histogram; reading a bin clears it to 0.
REQ-015 SHALL have port out_bin  output  10  bin number of out_data.
REQ-016 SHALL have port out_data  output  CNT_W  bin count.
REQ-017 SHALL have port out_valid  output  1  out_bin/out_data valid.
REQ-018 SHALL have port out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-019 SHALL have port out_last  output  1  marks bin NUM_BINS-1.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.
REQ-021 SHALL have port frame_drop  output  1  one-cycle pulse when a frame_start is ignored.
REQ-022 SHALL have port pix_count  output  CNT_W  valid pixels accumulated in the last frame; saturates at all-ones.

Function
REQ-023 SHALL implement the states IDLE, ACCUM, ADDR, WAIT, PRESENT and DONE.
REQ-024 IDLE: hist_rw=0, no forwarding; frame_start -> ACCUM, clears pix_count.
REQ-025 ACCUM: hist_rw=1; hist_pixel/hist_pixel_valid = pix_in/pix_valid_in, registered with 1-cycle latency; pix_count increments per valid pixel.
REQ-026 ACCUM: frame_end -> ADDR after the pipeline register flushes (one extra cycle with hist_rw=1); pixel valid on the frame_end cycle is counted.
REQ-027 ADDR: hist_rw=0, drive hist_bin = bin counter (starts 0) -> WAIT.
REQ-028 WAIT: hold hist_bin for RD_LAT cycles, then capture hist_data into out_data, set out_valid -> PRESENT.
REQ-029 PRESENT: hold out_* and hist_bin stable until transfer; on transfer, if bin = NUM_BINS-1 -> DONE, else bin+1 -> ADDR.
REQ-030 out_last SHALL equal (out_bin == NUM_BINS-1) while out_valid is high; out_valid SHALL not drop without a transfer.
REQ-031 DONE: one cycle, bin counter to 0 -> IDLE; minimum cadence 1 bin per RD_LAT+2 cycles.
REQ-032 frame_start outside IDLE SHALL be ignored and pulse frame_drop; frame_start and the DONE->IDLE transition in the same cycle SHALL also drop.
REQ-033 frame_end outside ACCUM SHALL be ignored.
REQ-034 frame_start and frame_end in the same IDLE cycle SHALL enter ACCUM and then go directly to ADDR (empty frame, all bins read as 0).
REQ-035 Hold time in PRESENT is unbounded; the repeated read of the same bin clears an already-captured value only.

Reset
REQ-036 rst SHALL force IDLE, bin counter 0, and all outputs (including hist_rw, out_valid, frame_drop, pix_count, out_data) to 0, asynchronously.
REQ-037 Reset mid-frame or mid-drain SHALL abandon the sequence with no transfer; histogram contents are not cleared by this block on reset.

Configuration
REQ-038 Macro HISTO_FRAME_CTRL_SUMCHK_EN: when defined, the block SHALL accumulate transferred out_data into a CNT_W+10-bit sum and add output sum_err (1 bit), set in DONE if sum != pix_count (unsaturated) and cleared on the next frame_start accept.
REQ-039 Without the macro, the sum_err port and the summing logic SHALL be absent.

Verification
REQ-040 Frame of 5 valid pixels {3,3,7,1023,0}, out_ready=1 -> 1024 transfers with bin3=2, bin7=1, bin1023=1, bin0=1, others 0; out_last on bin 1023; pix_count=5.
REQ-041 out_ready low 20 cycles at bin 7 -> out_data/out_bin stable for 20 cycles, single transfer of bin 7, no skipped bin.
REQ-042 frame_start during drain -> frame_drop pulse, busy stays 1, drain completes unaffected.
REQ-043 rst asserted at bin 500 -> next cycle IDLE, out_valid=0, busy=0; new frame reads from bin 0.
REQ-044 With HISTO_FRAME_CTRL_SUMCHK_EN, hist_data forced +1 on bin 9 -> sum_err=1 after DONE; clean frame -> sum_err=0.
REQ-045 frame_start+frame_end same cycle -> 1024 zero bins, pix_count=0.
